id_exe_stage_reg: RTL and testbench

- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM core.
- Captures decoded control and operand fields on each clock.
- Holds them under stall and converts them into a bubble under flush.
- Drives the execute stage, including the Val2 generator inputs (shifter_operand, imm, is_for_memory, val_Rm).

---
 rtl/id_exe_stage_reg_pkg.sv | 20 ++
 rtl/id_exe_stage_reg_pipe_reg.sv | 31 +++
 rtl/id_exe_stage_reg.sv | 125 ++++++++++++
 tb/tb_id_exe_stage_reg.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared width constants for the ID/EXE pipeline register, plus the
// saturating increment used by the flush-bubble counter.
package id_exe_stage_reg_pkg;

  localparam int WORD_WIDTH            = 32;
  localparam int SHIFTER_OPERAND_WIDTH = 12;
  localparam int REG_ADDR_WIDTH        = 4;
  localparam int EXE_CMD_WIDTH         = 4;
  localparam int STATUS_WIDTH          = 4;
  localparam int FLUSH_CNT_WIDTH       = 16;
  localparam int SIGNED_IMM_WIDTH      = 24;

  typedef logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_t;

  // Count up by one, sticking at all-ones instead of wrapping to zero.
  function automatic flush_cnt_t sat_inc(input flush_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + flush_cnt_t'(1);
  endfunction

endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (turns the stage into a bubble) taking priority over enable (hold).
module id_exe_stage_reg_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Register with clear > enable priority; holds when neither is active.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of the order blocks are evaluated.
    if (!rst) begin
      data_q <= '0;
    end else if (clr) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the 5-stage ARM core. Captures the decoded
// instruction each cycle, holds it under stall, and replaces it with an
// all-zero bubble under flush or when decode has no valid instruction.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::STATUS_WIDTH;
  import id_exe_stage_reg_pkg::FLUSH_CNT_WIDTH;
  import id_exe_stage_reg_pkg::SIGNED_IMM_WIDTH;
  import id_exe_stage_reg_pkg::flush_cnt_t;
  import id_exe_stage_reg_pkg::sat_inc;
#(
  parameter int WORD_WIDTH            = id_exe_stage_reg_pkg::WORD_WIDTH,
  parameter int SHIFTER_OPERAND_WIDTH = id_exe_stage_reg_pkg::SHIFTER_OPERAND_WIDTH,
  parameter int REG_ADDR_WIDTH        = id_exe_stage_reg_pkg::REG_ADDR_WIDTH,
  parameter int EXE_CMD_WIDTH         = id_exe_stage_reg_pkg::EXE_CMD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flush,
  input  logic                             id_valid,
  input  logic [WORD_WIDTH-1:0]            id_pc,
  input  logic [EXE_CMD_WIDTH-1:0]         id_exe_cmd,
  input  logic                             id_wb_en,
  input  logic                             id_mem_r_en,
  input  logic                             id_mem_w_en,
  input  logic                             id_b,
  input  logic                             id_s,
  input  logic                             id_imm,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] id_shifter_operand,
  input  logic [SIGNED_IMM_WIDTH-1:0]      id_signed_imm_24,
  input  logic [WORD_WIDTH-1:0]            id_val_rn,
  input  logic [WORD_WIDTH-1:0]            id_val_rm,
  input  logic [REG_ADDR_WIDTH-1:0]        id_dest,
  input  logic [REG_ADDR_WIDTH-1:0]        id_src1,
  input  logic [REG_ADDR_WIDTH-1:0]        id_src2,
  input  logic [STATUS_WIDTH-1:0]          id_status,
  output logic                             exe_valid,
  output logic [WORD_WIDTH-1:0]            exe_pc,
  output logic [EXE_CMD_WIDTH-1:0]         exe_exe_cmd,
  output logic                             exe_wb_en,
  output logic                             exe_mem_r_en,
  output logic                             exe_mem_w_en,
  output logic                             exe_b,
  output logic                             exe_s,
  output logic                             exe_imm,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] exe_shifter_operand,
  output logic [SIGNED_IMM_WIDTH-1:0]      exe_signed_imm_24,
  output logic [WORD_WIDTH-1:0]            exe_val_rn,
  output logic [WORD_WIDTH-1:0]            exe_val_rm,
  output logic [REG_ADDR_WIDTH-1:0]        exe_dest,
  output logic [REG_ADDR_WIDTH-1:0]        exe_src1,
  output logic [REG_ADDR_WIDTH-1:0]        exe_src2,
  output logic [STATUS_WIDTH-1:0]          exe_status,
  output logic                             exe_is_for_memory,
  output logic [FLUSH_CNT_WIDTH-1:0]       flush_count
);

  // Eight single-bit flags plus the ALU command and NZCV status.
  localparam int CTRL_W = 8 + EXE_CMD_WIDTH + STATUS_WIDTH;
  localparam int DATA_W = 3 * WORD_WIDTH + SHIFTER_OPERAND_WIDTH
                        + SIGNED_IMM_WIDTH + 3 * REG_ADDR_WIDTH;

  logic              stage_clr;
  logic              stage_en;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;
  flush_cnt_t        flush_count_d, flush_count_q;

  // A bubble is written on flush, or on a normal load of an invalid slot;
  // a stalled invalid slot must keep whatever the register already holds.
  assign stage_clr = flush | (~stall & ~id_valid);
  assign stage_en  = ~stall;

  assign ctrl_d = {id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s,
                   id_imm, id_mem_r_en | id_mem_w_en, id_exe_cmd, id_status};

  assign data_d = {id_pc, id_shifter_operand, id_signed_imm_24, id_val_rn,
                   id_val_rm, id_dest, id_src1, id_src2};

  id_exe_stage_reg_pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .clr (stage_clr),
    .en  (stage_en),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  id_exe_stage_reg_pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .clr (stage_clr),
    .en  (stage_en),
    .d   (data_d),
    .q   (data_q)
  );

  assign {exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s,
          exe_imm, exe_is_for_memory, exe_exe_cmd, exe_status} = ctrl_q;

  assign {exe_pc, exe_shifter_operand, exe_signed_imm_24, exe_val_rn,
          exe_val_rm, exe_dest, exe_src1, exe_src2} = data_q;

  // Next flush count: bump on every flush (stall is irrelevant, flush wins).
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    flush_count_d = flush_count_q;
    if (flush) begin
      flush_count_d = sat_inc(flush_count_q);
    end
  end

  // Flush counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
    end
  end

  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: a reset/stall/flush vector table,
// directed corner sequences, and randomized traffic against a stage model.
module tb_id_exe_stage_reg;
  import id_exe_stage_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc;
  logic [3:0]  id_exe_cmd;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
  logic [11:0] id_shifter_operand;
  logic [23:0] id_signed_imm_24;
  logic [31:0] id_val_rn, id_val_rm;
  logic [3:0]  id_dest, id_src1, id_src2, id_status;

  logic        exe_valid;
  logic [31:0] exe_pc;
  logic [3:0]  exe_exe_cmd;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm;
  logic [11:0] exe_shifter_operand;
  logic [23:0] exe_signed_imm_24;
  logic [31:0] exe_val_rn, exe_val_rm;
  logic [3:0]  exe_dest, exe_src1, exe_src2, exe_status;
  logic        exe_is_for_memory;
  logic [15:0] flush_count;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_exe_cmd(id_exe_cmd), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_b(id_b),
    .id_s(id_s), .id_imm(id_imm), .id_shifter_operand(id_shifter_operand),
    .id_signed_imm_24(id_signed_imm_24), .id_val_rn(id_val_rn),
    .id_val_rm(id_val_rm), .id_dest(id_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_status(id_status),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_exe_cmd(exe_exe_cmd),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b), .exe_s(exe_s),
    .exe_imm(exe_imm), .exe_shifter_operand(exe_shifter_operand),
    .exe_signed_imm_24(exe_signed_imm_24), .exe_val_rn(exe_val_rn),
    .exe_val_rm(exe_val_rm), .exe_dest(exe_dest), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_status(exe_status),
    .exe_is_for_memory(exe_is_for_memory), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Everything the execute stage sees, as one record.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  exe_cmd;
    logic        wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [11:0] shifter_operand;
    logic [23:0] signed_imm_24;
    logic [31:0] val_rn, val_rm;
    logic [3:0]  dest, src1, src2, status;
    logic        is_for_memory;
  } stage_t;

  typedef struct {
    bit       flush, stall, valid, wb_en;
    bit [3:0] dest;
    bit       e_valid, e_wb_en;
    bit [3:0] e_dest;
    int       e_cnt;
  } vec_t;

  stage_t m_stage;
  int     m_cnt;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stage_t from_inputs();
    stage_t s;
    s.valid = id_valid;           s.pc = id_pc;
    s.exe_cmd = id_exe_cmd;       s.wb_en = id_wb_en;
    s.mem_r_en = id_mem_r_en;     s.mem_w_en = id_mem_w_en;
    s.b = id_b;                   s.s = id_s;
    s.imm = id_imm;               s.shifter_operand = id_shifter_operand;
    s.signed_imm_24 = id_signed_imm_24;
    s.val_rn = id_val_rn;         s.val_rm = id_val_rm;
    s.dest = id_dest;             s.src1 = id_src1;
    s.src2 = id_src2;             s.status = id_status;
    s.is_for_memory = id_mem_r_en | id_mem_w_en;
    return s;
  endfunction

  function automatic stage_t from_dut();
    stage_t s;
    s.valid = exe_valid;          s.pc = exe_pc;
    s.exe_cmd = exe_exe_cmd;      s.wb_en = exe_wb_en;
    s.mem_r_en = exe_mem_r_en;    s.mem_w_en = exe_mem_w_en;
    s.b = exe_b;                  s.s = exe_s;
    s.imm = exe_imm;              s.shifter_operand = exe_shifter_operand;
    s.signed_imm_24 = exe_signed_imm_24;
    s.val_rn = exe_val_rn;        s.val_rm = exe_val_rm;
    s.dest = exe_dest;            s.src1 = exe_src1;
    s.src2 = exe_src2;            s.status = exe_status;
    s.is_for_memory = exe_is_for_memory;
    return s;
  endfunction

  // Reference behaviour of one clock edge: flush > stall > load/bubble.
  task automatic model_step();
    if (flush) begin
      m_stage = '0;
      if (m_cnt < 65535) m_cnt++;
    end else if (!stall) begin
      m_stage = id_valid ? from_inputs() : '0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_stage"}, from_dut(), m_stage);
    check({tag, "_cnt"}, flush_count, m_cnt);
  endtask

  // One edge: update model, sample 1ns later, return at the falling edge.
  task automatic tick(input bit do_check, input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (do_check) compare_model(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_pc = '0; id_exe_cmd = '0;
    id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; id_b = 0; id_s = 0;
    id_imm = 0; id_shifter_operand = '0; id_signed_imm_24 = '0;
    id_val_rn = '0; id_val_rm = '0; id_dest = '0; id_src1 = '0;
    id_src2 = '0; id_status = '0;
  endtask

  task automatic random_fields();
    id_pc = $urandom;             id_exe_cmd = 4'($urandom);
    id_wb_en = 1'($urandom);      id_mem_r_en = 1'($urandom);
    id_mem_w_en = 1'($urandom);   id_b = 1'($urandom);
    id_s = 1'($urandom);          id_imm = 1'($urandom);
    id_shifter_operand = 12'($urandom);
    id_signed_imm_24 = 24'($urandom);
    id_val_rn = $urandom;         id_val_rm = $urandom;
    id_dest = 4'($urandom);       id_src1 = 4'($urandom);
    id_src2 = 4'($urandom);       id_status = 4'($urandom);
  endtask

  task automatic apply_reset();
    rst = 0;
    m_stage = '0;
    m_cnt = 0;
  endtask

  vec_t vecs[9];

  initial begin
    //          flush stall valid wb dest   e_valid e_wb e_dest e_cnt
    vecs[0] = '{0, 0, 1, 1, 4'd3,  1, 1, 4'd3,  0};
    vecs[1] = '{0, 1, 1, 1, 4'd7,  1, 1, 4'd3,  0};
    vecs[2] = '{0, 1, 0, 0, 4'd7,  1, 1, 4'd3,  0};
    vecs[3] = '{0, 0, 0, 1, 4'd7,  0, 0, 4'd0,  0};
    vecs[4] = '{0, 1, 1, 1, 4'd8,  0, 0, 4'd0,  0};
    vecs[5] = '{1, 0, 1, 1, 4'd8,  0, 0, 4'd0,  1};
    vecs[6] = '{0, 0, 1, 0, 4'd12, 1, 0, 4'd12, 1};
    vecs[7] = '{1, 1, 1, 1, 4'd9,  0, 0, 4'd0,  2};
    vecs[8] = '{0, 0, 1, 1, 4'd15, 1, 1, 4'd15, 2};

    idle_inputs();
    apply_reset();
    #12;
    check("por_stage", from_dut(), stage_t'('0));
    check("por_cnt", flush_count, 16'h0);
    @(negedge clk);
    rst = 1;

    // Table: stall/flush/bubble interplay from a clean reset.
    foreach (vecs[i]) begin
      flush = vecs[i].flush;  stall = vecs[i].stall;
      id_valid = vecs[i].valid; id_wb_en = vecs[i].wb_en;
      id_dest = vecs[i].dest;
      tick(1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid", i), exe_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_wb", i), exe_wb_en, vecs[i].e_wb_en);
      check($sformatf("vec%0d_dest", i), exe_dest, vecs[i].e_dest);
      check($sformatf("vec%0d_cnt", i), flush_count, vecs[i].e_cnt);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      random_fields();
      flush = ($urandom_range(7) == 0);
      stall = ($urandom_range(3) == 0);
      id_valid = ($urandom_range(3) != 0);
      tick(1, "rand");
    end

    // Reset mid-cycle with a loaded register, then reload.
    idle_inputs();
    random_fields();
    id_pc = 32'h8000_0004;
    id_valid = 1;
    tick(1, "preload");
    #2;
    apply_reset();
    #1;
    check("rst_async_stage", from_dut(), stage_t'('0));
    check("rst_async_cnt", flush_count, 16'h0);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    id_valid = 1; id_pc = 32'h0000_0010; id_wb_en = 1;
    tick(1, "rst_reload");
    check("rst_reload_pc", exe_pc, 32'h10);
    check("rst_reload_wb", exe_wb_en, 1'b1);

    // Immediate / shifter-operand load, memory read.
    idle_inputs();
    id_valid = 1; id_imm = 1; id_shifter_operand = 12'h2FF;
    id_val_rm = 32'hDEAD_BEEF; id_mem_r_en = 1;
    tick(1, "load");
    check("load_shop", exe_shifter_operand, 12'h2FF);
    check("load_imm", exe_imm, 1'b1);
    check("load_valrm", exe_val_rm, 32'hDEAD_BEEF);
    check("load_mem", exe_is_for_memory, 1'b1);

    // Three stall cycles hold dest=5, release loads dest=9.
    idle_inputs();
    id_valid = 1; id_dest = 4'd5;
    tick(1, "stall_load");
    stall = 1; id_dest = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick(1, "stall_hold");
      check($sformatf("stall_hold%0d", i), exe_dest, 4'd5);
    end
    stall = 0;
    tick(1, "stall_rel");
    check("stall_rel_dest", exe_dest, 4'd9);

    // Flush together with stall kills a loaded store-with-writeback.
    idle_inputs();
    id_valid = 1; id_wb_en = 1; id_mem_w_en = 1; id_val_rn = 32'h1234_5678;
    tick(1, "fs_load");
    flush = 1; stall = 1;
    tick(1, "fs");
    check("fs_valid", exe_valid, 1'b0);
    check("fs_wb", exe_wb_en, 1'b0);
    check("fs_memw", exe_mem_w_en, 1'b0);
    check("fs_valrn", exe_val_rn, 32'h0);
    check("fs_cnt", flush_count, 16'd1);

    // Invalid decode slot becomes a bubble without counting as a flush.
    idle_inputs();
    id_valid = 0; id_wb_en = 1;
    tick(1, "bubble");
    check("bubble_wb", exe_wb_en, 1'b0);
    check("bubble_valid", exe_valid, 1'b0);
    check("bubble_cnt", flush_count, 16'd1);

    // Reset during a simultaneous stall+flush, held across an edge.
    idle_inputs();
    random_fields(); id_valid = 1;
    tick(1, "midrst_load");
    stall = 1; flush = 1;
    #2;
    apply_reset();
    #1;
    check("midrst_stage", from_dut(), stage_t'('0));
    @(posedge clk);
    #1;
    check("midrst_held_stage", from_dut(), stage_t'('0));
    check("midrst_held_cnt", flush_count, 16'h0);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    tick(1, "midrst_rel");

    // Saturation: 65535 flushes reach the ceiling, two more stay there.
    flush = 1;
    random_fields(); id_valid = 1;
    for (int i = 0; i < 65535; i++) tick(0, "");
    compare_model("sat_full");
    check("sat_full_cnt", flush_count, 16'hFFFF);
    for (int i = 0; i < 2; i++) tick(1, "sat_extra");
    check("sat_extra_cnt", flush_count, 16'hFFFF);
    flush = 0;
    tick(1, "sat_load");
    check("sat_load_cnt", flush_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
